gray_step_monitor: RTL and testbench
====================================

# gray_step_monitor

Downstream consumer of the 8-bit gray counter output. It synchronises a gray-coded count into the local clock domain and converts it to binary. Each change is classified as a legal +1 step, a legal -1 step, or an illegal jump, with pulses, direction and error statistics for the LED/OLED status logic. The source may run in a different clock domain; only single-bit transitions between samples are legal.

## Interface
- bits, 8: width of gray input and binary output
- sync_stages, 2: synchroniser flop count on gray_in (min 2)
- err_bits, 8: width of saturating error counter
- clk  in  1  sampling clock (clk_25mhz at top level)
- resn  in  1  reset, asynchronous, active-low
- gray_in  in  bits  gray-coded count, possibly asynchronous to clk
- clear  in  1  synchronous clear of err_sticky and err_count
- valid  out  1  high once a reference sample has been captured
- bin_out  out  bits  binary value of last synchronised sample
- step  out  1  one-cycle pulse on legal ±1 change
- dir  out  1  direction of last legal step, 1=up, 0=down
- err  out  1  one-cycle pulse on illegal change
- err_sticky  out  1  set by err, cleared only by clear or reset
- err_count  out  err_bits  saturating count of err pulses

## Operation
- Synchroniser s[0..sync_stages-1]: s[0]<=gray_in, s[i]<=s[i-1]; compare point is g=s[sync_stages-1].
- g converted to binary: b[bits-1]=g[bits-1], b[i]=b[i+1]^g[i].
- Internal prev_bin holds the last accepted binary value.
- States: INIT, TRACK.
- INIT (entered on reset): wait counter runs sync_stages edges. On the next edge, prev_bin<=b, bin_out<=b, valid<=1, go TRACK. No step/err in INIT.
- TRACK, each edge:
  - b==prev_bin: step=0, err=0, nothing else changes.
  - b==prev_bin+1 mod 2^bits: step=1, dir=1, bin_out<=b, prev_bin<=b.
  - b==prev_bin-1 mod 2^bits: step=1, dir=0, bin_out<=b, prev_bin<=b.
  - Otherwise: err=1, err_sticky<=1, err_count<=err_count+1 saturating at 2^err_bits-1. bin_out and prev_bin still resync to b; step=0; dir unchanged.
- Wrap-around: 2^bits-1 -> 0 is legal up; 0 -> 2^bits-1 is legal down.
- clear and err in the same cycle: the event is not lost. err_count<=1 and err_sticky<=1.
- clear alone: err_count<=0, err_sticky<=0. It does not affect valid, bin_out, dir or state.
- Saturated err_count holds its value; err_sticky stays 1.

## Timing
- Reset values: valid=0, bin_out=0, step=0, dir=0, err=0, err_sticky=0, err_count=0. Synchroniser and prev_bin=0, state=INIT.
- resn assertion clears all of the above immediately, without a clock edge, at any point in operation. Deassertion restarts INIT.
- valid rises on edge sync_stages+1 after the first edge with resn high (edge 3 for default).
- Latency: a gray_in change set up before edge k appears on bin_out/step/err after edge k+sync_stages (3 edges for default).
- step and err are mutually exclusive, each high exactly one cycle per classified change.
- Source changes faster than one step per clk produce err, by design.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset release with gray_in=0x00 held -> valid=0 after edges 1-2, valid=1 after edge 3, bin_out=0x00, step=0, err=0.
- Gray sequence 0x00,0x01,0x03,0x02, each held 4 cycles -> three step pulses, each 3 edges after its change, dir=1, bin_out 1,2,3, err=0.
- Wrap: from gray 0x80 (bin 255) drive 0x00 -> step, dir=1, bin_out=0. Then drive 0x80 -> step, dir=0, bin_out=255.
- Illegal: from 0x00 drive 0x03 (bin 2) -> err pulse, step=0, err_sticky=1, err_count=1, bin_out=2. Then 0x02 (bin 3) -> legal step, dir=1.
- 260 illegal jumps -> err_count=255, err_sticky=1. Pulse clear coincident with an err -> err_count=1, err_sticky=1. Clear alone -> err_count=0, err_sticky=0.
- Assert resn mid-sequence between clock edges -> all outputs 0 immediately. On release, valid re-rises 3 edges later with bin_out equal to the current gray_in decoded.

Source files
------------

// File: rtl/gray_step_monitor.sv
// Synchronises a gray-coded count into the local clock domain, converts it to binary and
// classifies every change as a legal +1/-1 step or an illegal jump, with error statistics.
module gray_step_monitor #(
  parameter int bits        = 8,
  parameter int sync_stages = 2,
  parameter int err_bits    = 8
) (
  input  logic                clk,
  input  logic                resn,
  input  logic [bits-1:0]     gray_in,
  input  logic                clear,
  output logic                valid,
  output logic [bits-1:0]     bin_out,
  output logic                step,
  output logic                dir,
  output logic                err,
  output logic                err_sticky,
  output logic [err_bits-1:0] err_count
);

  localparam int cnt_w = $clog2(sync_stages + 1);
  localparam logic [cnt_w-1:0] wait_last = cnt_w'(sync_stages);

  typedef enum logic {INIT, TRACK} state_t;

  state_t            state, state_d;
  logic [cnt_w-1:0]  wait_cnt;
  logic [bits-1:0]   sync_q [sync_stages];
  logic [bits-1:0]   g, b, prev_bin, prev_up, prev_dn;
  logic              capture, is_up, is_dn, is_bad;

  // gray_in may be asynchronous: only the last stage is ever compared
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g = sync_q[sync_stages-1];

  // b[i] is the xor of every gray bit at or above position i
  always_comb begin
    b = '0;
    for (int i = 0; i < bits; i++) b[i] = ^(g >> i);
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) state <= INIT;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (state == INIT && wait_cnt == wait_last) state_d = TRACK;
  end

  always_comb begin
    prev_up = prev_bin + bits'(1);
    prev_dn = prev_bin - bits'(1);
    capture = (state == INIT) && (wait_cnt == wait_last);
    is_up   = (state == TRACK) && (b == prev_up);
    is_dn   = (state == TRACK) && (b == prev_dn);
    is_bad  = (state == TRACK) && (b != prev_bin) && !is_up && !is_dn;
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      wait_cnt   <= '0;
      prev_bin   <= '0;
      valid      <= 1'b0;
      bin_out    <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      step <= is_up | is_dn;
      err  <= is_bad;
      if (state == INIT && !capture) wait_cnt <= wait_cnt + 1'b1;
      if (capture) valid <= 1'b1;
      // illegal jumps still resync so one glitch produces one error, not a stream
      if (capture || is_up || is_dn || is_bad) begin
        prev_bin <= b;
        bin_out  <= b;
      end
      if (is_up) dir <= 1'b1;
      if (is_dn) dir <= 1'b0;
      // a clear coinciding with an error keeps that error as the first new event
      if (clear) begin
        err_sticky <= is_bad;
        err_count  <= is_bad ? err_bits'(1) : '0;
      end else if (is_bad) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + err_bits'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: vector table, hand-written corner sequences and a pulse scoreboard.
module tb_gray_step_monitor;

  logic       clk = 1'b0;
  logic       resn;
  logic [7:0] gray_in;
  logic       clear;
  logic       valid;
  logic [7:0] bin_out;
  logic       step;
  logic       dir;
  logic       err;
  logic       err_sticky;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // packed record {bin_out, step, dir, err, err_sticky, err_count}
  logic [19:0] exp_q[$];

  typedef struct {
    logic [7:0] gray;
    logic [7:0] bin;
    logic       step;
    logic       dir;
    logic       err;
    logic       sticky;
    logic [7:0] count;
  } vec_t;

  vec_t vecs[14];

  gray_step_monitor #(.bits(8), .sync_stages(2), .err_bits(8)) dut (
    .clk        (clk),
    .resn       (resn),
    .gray_in    (gray_in),
    .clear      (clear),
    .valid      (valid),
    .bin_out    (bin_out),
    .step       (step),
    .dir        (dir),
    .err        (err),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] gr, bn, input logic st, dr, er, sk,
                              input logic [7:0] ct);
    vec_t v;
    v.gray = gr; v.bin = bn; v.step = st; v.dir = dr; v.err = er; v.sticky = sk; v.count = ct;
    return v;
  endfunction

  function automatic logic [7:0] to_gray(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: every step/err pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [19:0] act, e;
    if (step || err) begin
      checks++;
      act = {bin_out, step, dir, err, err_sticky, err_count};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_pulse actual=%0h expected=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL pulse actual=%0h expected=%0h", act, e);
        end
      end
    end
  end

  // driver: called at posedge+1, returns at posedge+1 four edges later
  task automatic apply_vec(input vec_t v);
    int n;
    gray_in = v.gray;
    if (v.step || v.err) exp_q.push_back({v.bin, v.step, v.dir, v.err, v.sticky, v.count});
    n = exp_q.size();
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    chk("not_early", n, exp_q.size());
    @(posedge clk); @(negedge clk); #1;
    chk("latency", exp_q.size(), 0);
    chk("bin_out", bin_out, v.bin);
    chk("dir", dir, v.dir);
    chk("sticky", err_sticky, v.sticky);
    chk("count", err_count, v.count);
    @(posedge clk); #1;
  endtask

  // called at posedge+1 right after resn is released
  task automatic init_seq(input logic [7:0] exp_bin);
    @(posedge clk); @(negedge clk);
    chk("valid_edge1", valid, 0);
    @(posedge clk); @(negedge clk);
    chk("valid_edge2", valid, 0);
    @(posedge clk); @(negedge clk);
    chk("valid_edge3", valid, 1);
    chk("init_bin", bin_out, exp_bin);
    chk("init_step", step, 0);
    chk("init_err", err, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_bin, exp_count, nb;
    logic       up;

    vecs[0]  = mk(8'h01, 8'd1,   1, 1, 0, 0, 8'd0);
    vecs[1]  = mk(8'h03, 8'd2,   1, 1, 0, 0, 8'd0);
    vecs[2]  = mk(8'h02, 8'd3,   1, 1, 0, 0, 8'd0);
    vecs[3]  = mk(8'h03, 8'd2,   1, 0, 0, 0, 8'd0);
    vecs[4]  = mk(8'h01, 8'd1,   1, 0, 0, 0, 8'd0);
    vecs[5]  = mk(8'h00, 8'd0,   1, 0, 0, 0, 8'd0);
    vecs[6]  = mk(8'h03, 8'd2,   0, 0, 1, 1, 8'd1);
    vecs[7]  = mk(8'h02, 8'd3,   1, 1, 0, 1, 8'd1);
    vecs[8]  = mk(8'h80, 8'd255, 0, 1, 1, 1, 8'd2);
    vecs[9]  = mk(8'h00, 8'd0,   1, 1, 0, 1, 8'd2);
    vecs[10] = mk(8'h80, 8'd255, 1, 0, 0, 1, 8'd2);
    vecs[11] = mk(8'h81, 8'd254, 1, 0, 0, 1, 8'd2);
    vecs[12] = mk(8'h80, 8'd255, 1, 1, 0, 1, 8'd2);
    vecs[13] = mk(8'h80, 8'd255, 0, 1, 0, 1, 8'd2);

    resn = 1'b0; gray_in = 8'h00; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_count", err_count, 0);
    resn = 1'b1;
    init_seq(8'h00);

    for (int i = 0; i < 14; i++) apply_vec(vecs[i]);

    // random legal walk
    exp_bin = 8'd255; exp_count = 8'd2;
    for (int i = 0; i < 16; i++) begin
      up = 1'($urandom_range(0, 1));
      nb = up ? exp_bin + 8'd1 : exp_bin - 8'd1;
      apply_vec(mk(to_gray(nb), nb, 1, up, 0, 1, exp_count));
      exp_bin = nb;
    end

    // back-to-back illegal jumps saturate the counter; the last legal dir is kept
    up = dir;
    for (int i = 0; i < 260; i++) begin
      nb = (i % 2 == 0) ? 8'h40 : 8'h42;
      if (exp_count != 8'hff) exp_count = exp_count + 8'd1;
      exp_q.push_back({nb, 1'b0, up, 1'b1, 1'b1, exp_count});
      gray_in = to_gray(nb);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("sat_drain", exp_q.size(), 0);
    chk("sat_count", err_count, 8'hff);
    chk("sat_sticky", err_sticky, 1);
    @(posedge clk); #1;

    // clear coinciding with an error: the error survives as count 1
    gray_in = to_gray(8'h40);
    exp_q.push_back({8'h40, 1'b0, up, 1'b1, 1'b1, 8'd1});
    @(posedge clk); @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk); #1;
    chk("clr_err_drain", exp_q.size(), 0);
    chk("clr_err_count", err_count, 1);
    chk("clr_err_sticky", err_sticky, 1);

    // clear alone
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk); #1;
    chk("clr_count", err_count, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_valid", valid, 1);
    chk("clr_bin", bin_out, 8'h40);
    chk("clr_dir", dir, up);
    @(posedge clk); #1;

    apply_vec(mk(to_gray(8'h44), 8'h44, 0, up, 1, 1, 8'd1));

    // asynchronous reset between edges
    @(posedge clk); #3;
    resn = 1'b0;
    gray_in = 8'h55;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_bin", bin_out, 0);
    chk("arst_step", step, 0);
    chk("arst_dir", dir, 0);
    chk("arst_err", err, 0);
    chk("arst_sticky", err_sticky, 0);
    chk("arst_count", err_count, 0);
    @(posedge clk); @(posedge clk); #1;
    resn = 1'b1;
    init_seq(8'h66);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
